// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO feeding a UART transmitter with start/txdone handshake and guard gap
// Optional: define UART_TX_FEEDER_DROP_CNT_EN to add the saturating drop_cnt output.
module uart_tx_feeder #(
    parameter int DEPTH        = 8,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     txdone,
    output logic                     start,
    output logic [7:0]               txin,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int GW    = $clog2(GUARD_CYCLES + 2);
    localparam int GLAST = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GUARD     = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_next;
    logic [GW-1:0]   guard_cnt;
    logic            wr_accept;
    logic            pop;

    // Writes are gated by the registered full flag, so a same-cycle pop never frees room for them.
    assign wr_accept = wr_en & ~full;
    assign pop       = (state == IDLE) & ~empty;

    always_comb begin
        level_next = level;
        if (wr_accept && !pop) begin
            level_next = level + LW'(1);
        end else if (!wr_accept && pop) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    // txin is only loaded on a pop, which holds it through WAIT_DONE, GUARD and the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start     <= 1'b0;
            txin      <= 8'h00;
            busy      <= 1'b0;
            guard_cnt <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        txin  <= mem[rd_ptr];
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (txdone) begin
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GW'(GLAST)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (wr_en && full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int G     = 4;
    localparam int TXGAP = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       txdone = 1'b0;
    logic       start;
    logic [7:0] txin;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       busy;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    uart_tx_feeder #(.DEPTH(DEPTH), .GUARD_CYCLES(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .txdone  (txdone),
        .start   (start),
        .txin    (txin),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .busy    (busy)
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every start pulse must carry the oldest accepted byte still outstanding.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && start === 1'b1) begin
            start_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_start txin=%h required=no start", txin);
            end else begin
                exp_b = sb.pop_front();
                if (txin !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_txin got=%h required=%h", txin, exp_b);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int t);
        t = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_timeout got=no start required=start within 300 cycles");
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({start, busy, empty, full} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_flags got=%b required=0010", {start, busy, empty, full});
        end
        n_cmp++;
        if (txin !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_txin got=%h required=00", txin);
        end
        n_cmp++;
        if (level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_level got=%0d required=0", level);
        end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_drop_cnt got=%h required=00", drop_cnt);
        end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int c;
        int t;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        c = cyc;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (empty !== 1'b0 || level !== 4'd1 || start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_write got=empty %b level %0d start %b required=empty 0 level 1 start 0", empty, level, start);
        end
        wait_start(t);
        n_cmp++;
        if (t != c + 2) begin
            n_fail++;
            $display("FAIL single_latency got=%0d required=%0d", t - c, 2);
        end
        n_cmp++;
        if (txin !== 8'hA5 || busy !== 1'b1 || empty !== 1'b1 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL single_at_start got=txin %h busy %b empty %b level %0d required=txin a5 busy 1 empty 1 level 0", txin, busy, empty, level);
        end
        @(negedge clk);
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse_width got=start %b busy %b required=start 0 busy 1", start, busy);
        end
        repeat (TXGAP - 1) @(posedge clk);
        #1 txdone = 1'b1;
        tick();
        txdone = 1'b0;
        repeat (G - 1) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || txin !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_last_guard got=busy %b txin %h required=busy 1 txin a5", busy, txin);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || txin !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_back_idle got=busy %b txin %h required=busy 0 txin a5", busy, txin);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wr_en = 1'b1;
                    wr_data = 8'(i + 1);
                    sb.push_back(8'(i + 1));
                    tick();
                end
                wr_en = 1'b0;
            end
            begin
                int t;
                int prev;
                prev = -1;
                for (int j = 0; j < 8; j++) begin
                    wait_start(t);
                    if (prev >= 0) begin
                        n_cmp++;
                        if (t - prev != TXGAP + G + 2) begin
                            n_fail++;
                            $display("FAIL b2b_spacing[%0d] got=%0d required=%0d", j, t - prev, TXGAP + G + 2);
                        end
                    end
                    prev = t;
                    repeat (TXGAP) @(posedge clk);
                    #1 txdone = 1'b1;
                    tick();
                    txdone = 1'b0;
                end
            end
        join
        repeat (G + 2) tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || empty !== 1'b1 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_drained got=busy %b empty %b level %0d required=busy 0 empty 1 level 0", busy, empty, level);
        end
        tick();
    endtask

    task automatic test_full_drop;
        int t;
        wr_en = 1'b1;
        wr_data = 8'h10;
        sb.push_back(8'h10);
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h11 + i);
            sb.push_back(8'(8'h11 + i));
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (full !== 1'b1 || level !== 4'd8) begin
            n_fail++;
            $display("FAIL full_filled got=full %b level %0d required=full 1 level 8", full, level);
        end
        tick();
        wr_en = 1'b1;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (full !== 1'b1 || level !== 4'd8) begin
            n_fail++;
            $display("FAIL full_drop_level got=full %b level %0d required=full 1 level 8", full, level);
        end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_cnt_first got=%0d required=1", drop_cnt);
        end
`endif
        tick();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        repeat (G) tick();
        // Now in the IDLE cycle that pops: this write collides with the pop and must be lost.
        wr_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (level !== 4'd7 || full !== 1'b0 || start !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_write_collide got=level %0d full %b start %b required=level 7 full 0 start 1", level, full, start);
        end
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        n_cmp++;
        if (drop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL drop_cnt_second got=%0d required=2", drop_cnt);
        end
`endif
        tick();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            wait_start(t);
            tick();
            txdone = 1'b1;
            tick();
            txdone = 1'b0;
        end
        repeat (G + 2) tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || empty !== 1'b1 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL full_drained got=busy %b empty %b level %0d required=busy 0 empty 1 level 0", busy, empty, level);
        end
        tick();
    endtask

    task automatic test_spurious_done;
        int c;
        int t;
        int s0;
        s0 = start_cnt;
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || start_cnt != s0) begin
            n_fail++;
            $display("FAIL idle_txdone got=busy %b starts %0d required=busy 0 starts %0d", busy, start_cnt, s0);
        end
        tick();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        sb.push_back(8'h5A);
        @(negedge clk);
        c = cyc;
        tick();
        wr_en = 1'b0;
        wait_start(t);
        n_cmp++;
        if (t != c + 2) begin
            n_fail++;
            $display("FAIL spurious_latency got=%0d required=2", t - c);
        end
        tick();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        tick();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || txin !== 8'h5A) begin
            n_fail++;
            $display("FAIL guard_txdone_hold got=busy %b txin %h required=busy 1 txin 5a", busy, txin);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || txin !== 8'h5A) begin
            n_fail++;
            $display("FAIL guard_txdone_exit got=busy %b txin %h required=busy 0 txin 5a", busy, txin);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int s0;
        int t;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h21 + i);
            sb.push_back(8'(8'h21 + i));
            tick();
        end
        wr_en = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (level !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before_reset got=level %0d busy %b required=level 5 busy 1", level, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({start, txin, busy, empty, full, level} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got=%b required=%b", {start, txin, busy, empty, full, level},
                     {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        sb.delete();
        s0 = start_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        n_cmp++;
        if (start_cnt != s0 || busy !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_after_release got=starts %0d busy %b level %0d required=starts %0d busy 0 level 0",
                     start_cnt, busy, level, s0);
        end
        tick();
        wr_en = 1'b1;
        wr_data = 8'h77;
        sb.push_back(8'h77);
        tick();
        wr_en = 1'b0;
        wait_start(t);
        tick();
        txdone = 1'b1;
        tick();
        txdone = 1'b0;
        repeat (G + 2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drop();
        test_spurious_done();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d bytes required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
